// File: rtl/mips32_pkg.sv
// Shared constants for the MIPS32 EX->MEM slice:
// branch encodings, payload layout and buffer states.
package mips32_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;

  // Payload layout, LSB first:
  // exc_ov, mem_write, mem_read, reg_write,
  // rd, store_data, alu_out.
  localparam int OFF_EXC = 0;
  localparam int OFF_MW  = 1;
  localparam int OFF_MR  = 2;
  localparam int OFF_RW  = 3;
  localparam int OFF_RD  = 4;

  function automatic int off_sd(input int rw);
    return OFF_RD + rw;
  endfunction

  function automatic int off_alu(
    input int dw,
    input int rw
  );
    return OFF_RD + rw + dw;
  endfunction

  function automatic int exm_w(
    input int dw,
    input int rw
  );
    return OFF_RD + rw + 2 * dw;
  endfunction

  localparam int EX_MEM_W = exm_w(DW, RW);

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_ONE   = 2'd1,
    SB_FULL  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/mips32_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush.
// Ports: clk, rst, flush, in_* (valid/ready/data), out_* (valid/ready/data).
module mips32_skid_buf
  import mips32_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  sb_state_e        state_q;
  sb_state_e        state_d;
  logic             ready_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             acc;
  logic             drn;
  logic             load_main;
  logic             load_skid;
  logic             move_skid;

  assign out_valid = (state_q != SB_EMPTY);
  assign out_data  = main_q;
  assign in_ready  = ready_q;

  assign acc = in_valid & ready_q & ~flush;
  assign drn = out_valid & out_ready;

  // ready is registered from the next state so
  // it never depends combinationally on out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SB_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SB_FULL);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = SB_EMPTY;
    end else begin
      unique case (state_q)
        SB_EMPTY: begin
          if (acc) state_d = SB_ONE;
        end
        SB_ONE: begin
          if (acc && !drn)
            state_d = SB_FULL;
          else if (drn && !acc)
            state_d = SB_EMPTY;
        end
        SB_FULL: begin
          if (drn) state_d = SB_ONE;
        end
        default: state_d = SB_EMPTY;
      endcase
    end
  end

  always_comb begin
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (!flush) begin
      unique case (state_q)
        SB_EMPTY: load_main = acc;
        SB_ONE: begin
          load_main = acc & drn;
          load_skid = acc & ~drn;
        end
        SB_FULL: move_skid = drn;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)
        main_q <= in_data;
      else if (move_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_data;
    end
  end

endmodule

// File: rtl/mips32_ex_mem_stage.sv
// EX->MEM pipeline stage: captures ALU result, resolves branches,
// turns overflow into an exception. Ports: ex_* in, mem_* out, redirect_*.
module mips32_ex_mem_stage
  import mips32_pkg::*;
#(
  parameter int DATAWIDTH = DW,
  parameter int REGW      = RW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [DATAWIDTH-1:0] ex_alu_out,
  input  logic                 ex_zero,
  input  logic                 ex_less,
  input  logic                 ex_overflow,
  input  logic [DATAWIDTH-1:0] ex_store_data,
  input  logic [REGW-1:0]      ex_rd,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic [2:0]           ex_br_type,
  input  logic [DATAWIDTH-1:0] ex_br_target,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [DATAWIDTH-1:0] mem_alu_out,
  output logic [DATAWIDTH-1:0] mem_store_data,
  output logic [REGW-1:0]      mem_rd,
  output logic                 mem_reg_write,
  output logic                 mem_mem_read,
  output logic                 mem_mem_write,
  output logic                 mem_exc_ov,
  output logic                 redirect_valid,
  output logic [DATAWIDTH-1:0] redirect_pc
);

  localparam int PW   = exm_w(DATAWIDTH, REGW);
  localparam int O_SD = off_sd(REGW);
  localparam int O_AL = off_alu(DATAWIDTH, REGW);

  logic [PW-1:0]        in_pl;
  logic [PW-1:0]        out_pl;
  logic                 accept;
  logic                 taken;
  logic                 redir_q;
  logic [DATAWIDTH-1:0] redir_pc_q;

  assign accept = ex_valid & ex_ready & ~flush;

  // an overflowing op keeps its raw sum but
  // must not touch the register file or memory
  assign in_pl = {
    ex_alu_out,
    ex_store_data,
    ex_rd,
    ex_reg_write & ~ex_overflow,
    ex_mem_read  & ~ex_overflow,
    ex_mem_write & ~ex_overflow,
    ex_overflow
  };

  mips32_skid_buf #(
    .WIDTH (PW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (ex_valid),
    .in_ready  (ex_ready),
    .in_data   (in_pl),
    .out_valid (mem_valid),
    .out_ready (mem_ready),
    .out_data  (out_pl)
  );

  assign mem_alu_out    = out_pl[O_AL +: DATAWIDTH];
  assign mem_store_data = out_pl[O_SD +: DATAWIDTH];
  assign mem_rd         = out_pl[OFF_RD +: REGW];
  assign mem_reg_write  = out_pl[OFF_RW];
  assign mem_mem_read   = out_pl[OFF_MR];
  assign mem_mem_write  = out_pl[OFF_MW];
  assign mem_exc_ov     = out_pl[OFF_EXC];

  always_comb begin
    taken = 1'b0;
    unique case (ex_br_type)
      BR_NONE: taken = 1'b0;
      BR_BEQ:  taken = ex_zero;
      BR_BNE:  taken = ~ex_zero;
      BR_BLT:  taken = ex_less;
      BR_BGE:  taken = ~ex_less;
      default: taken = 1'b0;
    endcase
  end

  // redirect fires on acceptance, independent
  // of whether MEM has drained the entry yet
  always_ff @(posedge clk) begin
    if (rst) begin
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      redir_q <= accept & taken;
      if (accept && taken)
        redir_pc_q <= ex_br_target;
    end
  end

  assign redirect_valid = redir_q;
  assign redirect_pc    = redir_pc_q;

endmodule
